register_file_mp: RTL and testbench

Parametrised multi-port register file with write-through bypass, per-register pending (scoreboard) bits, synchronous bulk clear and an optional hardwired-zero register. It succeeds the fixed 4×8-bit, two-read-port register file and feeds operands to the ALU datapath. It also lets the control unit stall on registers whose results have not been written back yet.

---
 rtl/register_file_mp_pkg.sv | 11 +
 rtl/register_file_mp_read_port.sv | 31 +++
 rtl/register_file_mp.sv | 66 ++++++
 tb/tb_register_file_mp.sv | 119 +++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared types and address helper for the multi-port register file
package register_file_mp_pkg;
  localparam int RF_DATA_W = 8;
  localparam int RF_NUM_REGS = 8;
  localparam int RF_ADDR_W = $clog2(RF_NUM_REGS);
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
  function automatic logic rf_addr_valid(input int unsigned addr, input int unsigned num_regs = RF_NUM_REGS);
    return addr < num_regs;
  endfunction
endpackage

// File: rtl/register_file_mp_read_port.sv
// rf_read_port: one combinational read mux with write-through bypass and ready logic
module rf_read_port
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 8,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]        pending,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          dest_select,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic [ADDR_W-1:0]          sel,
  output logic [DATA_W-1:0]          data,
  output logic                       ready
);
  logic valid, zero, bypass, pend;
  logic [DATA_W-1:0] stored;
  // Stored value first, then bypass; out-of-range and hardwired-zero reads force 0 and ready
  always_comb begin
    valid = rf_addr_valid(32'(sel), NUM_REGS);
    zero = ZERO_REG != 0 && sel == '0;
    bypass = wr_en && dest_select == sel;
    stored = valid ? regs[32'(sel)*DATA_W +: DATA_W] : '0;
    pend = valid && pending[sel];
    data = (!valid || zero) ? '0 : bypass ? reg_data : stored;
    ready = !valid || zero || bypass || !pend;
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with bypass, pending bits, bulk clear and optional zero register
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_clear,
  input  logic                     load_enable,
  input  logic [ADDR_W-1:0]        dest_select,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     reserve_en,
  input  logic [ADDR_W-1:0]        reserve_select,
  input  logic [NUM_RD*ADDR_W-1:0] rd_select,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  output logic                     any_pending
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic wr_en, rs_en;
  // Qualified strobes: nothing lands under reset, beyond NUM_REGS or on the hardwired zero register
  always_comb begin
    wr_en = reset_n && load_enable && rf_addr_valid(32'(dest_select), NUM_REGS)
            && !(ZERO_REG != 0 && dest_select == '0);
    rs_en = reserve_en && rf_addr_valid(32'(reserve_select), NUM_REGS)
            && !(ZERO_REG != 0 && reserve_select == '0);
  end
  // Storage and pending bits; the reserve is applied after the write so a same-register reserve wins
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      regs <= '{default: '0};
      pending <= '0;
    end else if (sync_clear) begin
      regs <= '{default: '0};
      pending <= '0;
    end else begin
      if (wr_en) begin
        regs[dest_select] <= reg_data;
        pending[dest_select] <= 1'b0;
      end
      if (rs_en) pending[reserve_select] <= 1'b1;
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_port (
      .regs(regs_flat),
      .pending(pending),
      .wr_en(wr_en),
      .dest_select(dest_select),
      .reg_data(reg_data),
      .sel(rd_select[k*ADDR_W +: ADDR_W]),
      .data(rd_data[k*DATA_W +: DATA_W]),
      .ready(rd_ready[k])
    );
  end
  assign any_pending = |pending;
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: table-driven scoreboard bench for register_file_mp (plain and zero-register instances)
module tb_register_file_mp;
  typedef struct {
    string name;
    bit z;
    logic le; logic [2:0] dst; logic [7:0] d;
    logic re; logic [2:0] rs; logic clr;
    logic [2:0] s0, s1;
    logic [7:0] e0, e1; logic [1:0] er; logic ep;
  } vec_t;

  logic clk = 0, reset_n = 0, sync_clear = 0, load_enable = 0, reserve_en = 0;
  logic [2:0] dest_select = 0, reserve_select = 0;
  logic [7:0] reg_data = 0;
  logic [5:0] rd_select = 0;
  logic [15:0] rd_a, rd_z;
  logic [1:0] rr_a, rr_z;
  logic ap_a, ap_z;
  int tests = 0, failed = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  register_file_mp #(.ZERO_REG(0)) dut (
    .clk(clk), .reset_n(reset_n), .sync_clear(sync_clear), .load_enable(load_enable),
    .dest_select(dest_select), .reg_data(reg_data), .reserve_en(reserve_en),
    .reserve_select(reserve_select), .rd_select(rd_select), .rd_data(rd_a),
    .rd_ready(rr_a), .any_pending(ap_a));

  register_file_mp #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset_n(reset_n), .sync_clear(sync_clear), .load_enable(load_enable),
    .dest_select(dest_select), .reg_data(reg_data), .reserve_en(reserve_en),
    .reserve_select(reserve_select), .rd_select(rd_select), .rd_data(rd_z),
    .rd_ready(rr_z), .any_pending(ap_z));

  function automatic vec_t mk(string n, bit z, bit le, int dst, int d, bit re, int rs, bit clr,
                              int s0, int s1, int e0, int e1, int er, int ep);
    vec_t v;
    v.name = n; v.z = z; v.le = le; v.dst = 3'(dst); v.d = 8'(d);
    v.re = re; v.rs = 3'(rs); v.clr = clr; v.s0 = 3'(s0); v.s1 = 3'(s1);
    v.e0 = 8'(e0); v.e1 = 8'(e1); v.er = 2'(er); v.ep = 1'(ep);
    return v;
  endfunction

  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    load_enable = v.le; dest_select = v.dst; reg_data = v.d;
    reserve_en = v.re; reserve_select = v.rs; sync_clear = v.clr;
    rd_select = {v.s1, v.s0};
  endtask

  task automatic check(vec_t v);
    vec_t e;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    cmp({e.name, "/d0"}, e.z ? rd_z[7:0] : rd_a[7:0], e.e0);
    cmp({e.name, "/d1"}, e.z ? rd_z[15:8] : rd_a[15:8], e.e1);
    cmp({e.name, "/rdy"}, e.z ? rr_z : rr_a, e.er);
    cmp({e.name, "/anyp"}, e.z ? ap_z : ap_a, e.ep);
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    drive(v);
    check(v);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk("fill", 0, 1, i, i + 1, 0, 0, 0, i, i == 0 ? 0 : i - 1, i + 1, i == 0 ? 1 : i, 3, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk("readback", 0, 0, 0, 0, 0, 0, 0, i, 7 - i, i + 1, 8 - i, 3, 0));
    tbl.push_back(mk("z_wr130", 1, 1, 1, 130, 0, 0, 0, 1, 0, 'h82, 0, 3, 0));
    tbl.push_back(mk("z_wr255", 1, 1, 3, 255, 0, 0, 0, 3, 1, 'hFF, 'h82, 3, 0));
    tbl.push_back(mk("z_wr0", 1, 1, 0, 7, 0, 0, 0, 0, 3, 0, 'hFF, 3, 0));
    tbl.push_back(mk("z_read", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h82, 3, 0));
    tbl.push_back(mk("a_read", 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'h82, 3, 0));
    tbl.push_back(mk("rsv5", 0, 0, 0, 0, 1, 5, 0, 5, 5, 6, 6, 3, 0));
    tbl.push_back(mk("rsv5_pend", 0, 0, 0, 0, 0, 0, 0, 0, 5, 7, 6, 1, 1));
    tbl.push_back(mk("wr5_bypass", 0, 1, 5, 'h6E, 0, 0, 0, 4, 5, 5, 'h6E, 3, 1));
    tbl.push_back(mk("wr5_cleared", 0, 0, 0, 0, 0, 0, 0, 5, 5, 'h6E, 'h6E, 3, 0));
    tbl.push_back(mk("collide", 0, 1, 2, 'h11, 1, 2, 0, 2, 0, 'h11, 7, 3, 0));
    tbl.push_back(mk("collide_after", 0, 0, 0, 0, 0, 0, 0, 2, 2, 'h11, 'h11, 0, 1));
    tbl.push_back(mk("z_rsv0", 1, 0, 0, 0, 1, 0, 0, 0, 2, 0, 'h11, 1, 1));
    tbl.push_back(mk("z_rsv0_after", 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 'h11, 1, 1));
    tbl.push_back(mk("a_rsv0_after", 0, 0, 0, 0, 0, 0, 0, 0, 2, 7, 'h11, 0, 1));
    tbl.push_back(mk("clr_wr", 0, 1, 3, 100, 0, 0, 1, 3, 2, 'h64, 'h11, 1, 1));
    tbl.push_back(mk("clr_after", 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 3, 0));
    tbl.push_back(mk("clr_after2", 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 3, 0));
    tbl.push_back(mk("z_clr_after", 1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 3, 0));
    tbl.push_back(mk("pre_rst_wr", 0, 1, 4, 'h55, 1, 6, 0, 4, 6, 'h55, 0, 3, 0));
    tbl.push_back(mk("pre_rst_state", 0, 0, 0, 0, 0, 0, 0, 4, 6, 'h55, 0, 1, 1));

    step(mk("rst_blocked", 0, 1, 0, 'hAA, 0, 0, 0, 0, 1, 0, 0, 3, 0));
    check(mk("z_rst_blocked", 1, 1, 0, 'hAA, 0, 0, 0, 0, 1, 0, 0, 3, 0));
    load_enable = 0;
    reset_n = 1;
    foreach (tbl[i]) step(tbl[i]);

    reset_n = 0;
    check(mk("async_rst", 0, 0, 0, 0, 0, 0, 0, 4, 6, 0, 0, 3, 0));
    step(mk("rst_wr_blocked", 0, 1, 4, 'hAA, 0, 0, 0, 4, 6, 0, 0, 3, 0));
    reset_n = 1;
    check(mk("release_bypass", 0, 1, 4, 'hAA, 0, 0, 0, 4, 6, 'hAA, 0, 3, 0));
    step(mk("release_stored", 0, 0, 0, 0, 0, 0, 0, 4, 6, 'hAA, 0, 3, 0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
